// File: rtl/coproc_mem_arbiter_pkg.sv
// Shared widths and port encoding for the
// coprocessor memory arbiter slice.
package coproc_mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1536;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    HOST = 1'b0,
    COP  = 1'b1
  } port_e;

endpackage

// File: rtl/coproc_mem_arbiter_if.sv
// Host/cop Avalon-MM slave ports plus the
// single memory port, bundled for the arbiter.
interface coproc_mem_arbiter_if #(
  parameter int DATA_W = coproc_mem_pkg::DATA_W,
  parameter int ADDR_W = coproc_mem_pkg::ADDR_W
);

  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] h_address;
  logic [BE_W-1:0]   h_byteenable;
  logic              h_read;
  logic              h_write;
  logic [DATA_W-1:0] h_writedata;
  logic              h_waitrequest;
  logic [DATA_W-1:0] h_readdata;
  logic              h_readdatavalid;

  logic [ADDR_W-1:0] c_address;
  logic [BE_W-1:0]   c_byteenable;
  logic              c_read;
  logic              c_write;
  logic [DATA_W-1:0] c_writedata;
  logic              c_waitrequest;
  logic [DATA_W-1:0] c_readdata;
  logic              c_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  h_address, h_byteenable,
    input  h_read, h_write, h_writedata,
    output h_waitrequest, h_readdata,
    output h_readdatavalid,
    input  c_address, c_byteenable,
    input  c_read, c_write, c_writedata,
    output c_waitrequest, c_readdata,
    output c_readdatavalid,
    output mem_address, mem_byteenable,
    output mem_chipselect, mem_write,
    output mem_writedata,
    input  mem_readdata
  );

  modport master (
    output h_address, h_byteenable,
    output h_read, h_write, h_writedata,
    input  h_waitrequest, h_readdata,
    input  h_readdatavalid,
    output c_address, c_byteenable,
    output c_read, c_write, c_writedata,
    input  c_waitrequest, c_readdata,
    input  c_readdatavalid,
    input  mem_address, mem_byteenable,
    input  mem_chipselect, mem_write,
    input  mem_writedata,
    output mem_readdata
  );

endinterface

// File: rtl/coproc_mem_arbiter_rr.sv
// Two-request round-robin grant with the
// last_grant history register.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  import coproc_mem_pkg::*;

  port_e last_grant;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (last_grant == COP)
          gnt = 2'b01;
        else
          gnt = 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

  // COP at reset so the host wins the first clash
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_grant <= COP;
    else if (gnt[1])
      last_grant <= COP;
    else if (gnt[0])
      last_grant <= HOST;
  end

endmodule

// File: rtl/coproc_mem_arbiter.sv
// Shares the single-port coprocessor memory
// between the host and coprocessor ports.
module coproc_mem_arbiter #(
  parameter int DATA_W = coproc_mem_pkg::DATA_W,
  parameter int ADDR_W = coproc_mem_pkg::ADDR_W,
  parameter int DEPTH  = coproc_mem_pkg::DEPTH
) (
  input logic                 clk,
  input logic                 reset_n,
  coproc_mem_arbiter_if.slave bus
);

  import coproc_mem_pkg::*;

  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W + 1)'(DEPTH);

  logic              h_req;
  logic              c_req;
  logic [1:0]        gnt;
  logic              granted;
  logic              sel_cop;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic              in_range;
  logic              rd_issue;
  logic              h_rdv;
  logic              c_rdv;

  logic              rd_pend;
  port_e             rd_port;
  logic              rd_oor;

  assign h_req = bus.h_read | bus.h_write;
  assign c_req = bus.c_read | bus.c_write;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({c_req, h_req}),
    .gnt     (gnt)
  );

  assign granted = |gnt;
  assign sel_cop = gnt[1];

  // Idle cycles keep host values on mem_*
  assign sel_addr = sel_cop ? bus.c_address
                            : bus.h_address;
  assign sel_wr   = sel_cop ? bus.c_write
                            : bus.h_write;

  assign in_range = {1'b0, sel_addr} < LIMIT;

  assign bus.mem_address    = sel_addr;
  assign bus.mem_byteenable =
    sel_cop ? bus.c_byteenable
            : bus.h_byteenable;
  assign bus.mem_writedata  =
    sel_cop ? bus.c_writedata
            : bus.h_writedata;

  assign bus.mem_chipselect =
    reset_n & granted & in_range;
  assign bus.mem_write =
    bus.mem_chipselect & sel_wr;

  assign bus.h_waitrequest = h_req & ~gnt[0];
  assign bus.c_waitrequest = c_req & ~gnt[1];

  assign rd_issue = granted & ~sel_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_port <= HOST;
      rd_oor  <= 1'b0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) begin
        rd_port <= sel_cop ? COP : HOST;
        rd_oor  <= ~in_range;
      end
    end
  end

  assign h_rdv = rd_pend & (rd_port == HOST);
  assign c_rdv = rd_pend & (rd_port == COP);

  assign bus.h_readdatavalid = h_rdv;
  assign bus.c_readdatavalid = c_rdv;

  assign bus.h_readdata =
    (h_rdv & ~rd_oor) ? bus.mem_readdata : '0;
  assign bus.c_readdata =
    (c_rdv & ~rd_oor) ? bus.mem_readdata : '0;

endmodule

// File: tb/tb_coproc_mem_arbiter.sv
// Directed scoreboard bench for the
// coprocessor memory arbiter.
module tb_coproc_mem_arbiter;

  import coproc_mem_pkg::*;

  typedef struct {
    port_e       port;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  coproc_mem_arbiter_if bus ();

  coproc_mem_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  exp_t sb[$];

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata = 32'h0;
  int          mem_writes = 0;

  assign bus.mem_readdata = rdata;

  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b])
            mem[bus.mem_address][8*b +: 8] <=
              bus.mem_writedata[8*b +: 8];
        mem_writes <= mem_writes + 1;
      end else begin
        rdata <= mem[bus.mem_address];
      end
    end
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic push(
    input port_e       p,
    input logic [31:0] d
  );
    exp_t e;
    e.port = p;
    e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per return
  always @(negedge clk) begin : mon
    exp_t e;
    if ((bus.h_read & bus.h_write) ||
        (bus.c_read & bus.c_write)) begin
      checks++;
      failures++;
      $display("FAIL proto: read+write on a port");
    end
    if (bus.h_readdatavalid &&
        bus.c_readdatavalid) begin
      checks++;
      failures++;
      $display("FAIL rdv_both: got 1 1 want one");
    end else if (bus.h_readdatavalid ||
                 bus.c_readdatavalid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdv_unexp: got %b%b want 00",
                 bus.h_readdatavalid,
                 bus.c_readdatavalid);
      end else begin
        e = sb.pop_front();
        if (bus.h_readdatavalid) begin
          chk("rd_port", 32'(HOST), 32'(e.port));
          chk("rd_data", bus.h_readdata, e.data);
          chk("c_rd_zero", bus.c_readdata, 0);
        end else begin
          chk("rd_port", 32'(COP), 32'(e.port));
          chk("rd_data", bus.c_readdata, e.data);
          chk("h_rd_zero", bus.h_readdata, 0);
        end
      end
    end
  end

  task automatic drive(
    input port_e       p,
    input logic        rd,
    input logic        wr,
    input logic [10:0] a,
    input logic [3:0]  be,
    input logic [31:0] d
  );
    if (p == HOST) begin
      bus.h_read       = rd;
      bus.h_write      = wr;
      bus.h_address    = a;
      bus.h_byteenable = be;
      bus.h_writedata  = d;
    end else begin
      bus.c_read       = rd;
      bus.c_write      = wr;
      bus.c_address    = a;
      bus.c_byteenable = be;
      bus.c_writedata  = d;
    end
  endtask

  task automatic idle(input port_e p);
    drive(p, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int wbefore;

  initial begin
    for (int i = 0; i < DEPTH; i++)
      mem[i] = 32'h0;
    idle(HOST);
    idle(COP);

    @(negedge clk);
    chk("rst_h_rdv", 32'(bus.h_readdatavalid), 0);
    chk("rst_c_rdv", 32'(bus.c_readdatavalid), 0);
    chk("rst_h_rd", bus.h_readdata, 0);
    chk("rst_c_rd", bus.c_readdata, 0);
    chk("rst_cs", 32'(bus.mem_chipselect), 0);
    chk("rst_mw", 32'(bus.mem_write), 0);
    tick();
    reset_n = 1'b1;

    // Host write then readback
    drive(HOST, 0, 1, 11'h010, 4'hF, 32'h12345678);
    @(negedge clk);
    chk("w_wait", 32'(bus.h_waitrequest), 0);
    chk("w_cs", 32'(bus.mem_chipselect), 1);
    chk("w_mw", 32'(bus.mem_write), 1);
    chk("w_addr", 32'(bus.mem_address), 32'h010);
    tick();
    drive(HOST, 1, 0, 11'h010, 4'hF, 32'h0);
    push(HOST, 32'h12345678);
    @(negedge clk);
    chk("r_wait", 32'(bus.h_waitrequest), 0);
    chk("r_mw", 32'(bus.mem_write), 0);
    tick();
    idle(HOST);
    @(negedge clk);
    chk("r_lat", 32'(bus.h_readdatavalid), 1);
    tick();

    // Preload 0xA / 0xB, cop granted last
    drive(HOST, 0, 1, 11'h000, 4'hF, 32'hA);
    tick();
    idle(HOST);
    drive(COP, 0, 1, 11'h001, 4'hF, 32'hB);
    tick();
    idle(COP);

    // Continuous contention alternates H,C
    drive(HOST, 1, 0, 11'h000, 4'hF, 32'h0);
    drive(COP, 1, 0, 11'h001, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        push(HOST, 32'hA);
      else
        push(COP, 32'hB);
      @(negedge clk);
      chk("ct_h_wait", 32'(bus.h_waitrequest),
          32'(i % 2));
      chk("ct_c_wait", 32'(bus.c_waitrequest),
          32'(1 - (i % 2)));
      tick();
    end
    idle(HOST);
    idle(COP);
    tick();

    // Byte-lane merge
    drive(HOST, 0, 1, 11'h020, 4'hF, 32'hFFFFFFFF);
    tick();
    idle(HOST);
    drive(COP, 0, 1, 11'h020, 4'b0010, 32'h0000AA00);
    tick();
    drive(COP, 1, 0, 11'h020, 4'hF, 32'h0);
    push(COP, 32'hFFFFAAFF);
    tick();
    idle(COP);
    tick();

    // Out-of-range read and write
    drive(HOST, 1, 0, 11'h600, 4'hF, 32'h0);
    push(HOST, 32'h0);
    @(negedge clk);
    chk("oor_r_cs", 32'(bus.mem_chipselect), 0);
    chk("oor_r_wait", 32'(bus.h_waitrequest), 0);
    tick();
    idle(HOST);
    @(negedge clk);
    chk("oor_r_lat", 32'(bus.h_readdatavalid), 1);
    tick();
    wbefore = mem_writes;
    drive(HOST, 0, 1, 11'h7FF, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("oor_w_cs", 32'(bus.mem_chipselect), 0);
    chk("oor_w_mw", 32'(bus.mem_write), 0);
    chk("oor_w_wait", 32'(bus.h_waitrequest), 0);
    tick();
    idle(HOST);
    tick();
    chk("oor_nowrite", 32'(mem_writes),
        32'(wbefore));

    // Reset right after a read accept
    drive(HOST, 1, 0, 11'h010, 4'hF, 32'h0);
    tick();
    reset_n = 1'b0;
    drive(HOST, 1, 0, 11'h000, 4'hF, 32'h0);
    drive(COP, 1, 0, 11'h001, 4'hF, 32'h0);
    @(negedge clk);
    chk("rr_h_rdv", 32'(bus.h_readdatavalid), 0);
    chk("rr_c_rdv", 32'(bus.c_readdatavalid), 0);
    chk("rr_h_rd", bus.h_readdata, 0);
    chk("rr_cs", 32'(bus.mem_chipselect), 0);
    chk("rr_mw", 32'(bus.mem_write), 0);
    chk("rr_h_wait", 32'(bus.h_waitrequest), 0);
    chk("rr_c_wait", 32'(bus.c_waitrequest), 1);
    tick();
    idle(HOST);
    idle(COP);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_h_rdv", 32'(bus.h_readdatavalid), 0);
    tick();

    // First conflict after reset: host wins
    drive(HOST, 1, 0, 11'h000, 4'hF, 32'h0);
    drive(COP, 1, 0, 11'h001, 4'hF, 32'h0);
    push(HOST, 32'hA);
    @(negedge clk);
    chk("fc_h_wait", 32'(bus.h_waitrequest), 0);
    chk("fc_c_wait", 32'(bus.c_waitrequest), 1);
    tick();
    idle(HOST);
    push(COP, 32'hB);
    @(negedge clk);
    chk("fc_c_wait2", 32'(bus.c_waitrequest), 0);
    tick();
    idle(COP);
    repeat (3) tick();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
